// File: rtl/fsm_101_pkg.sv
// ============================================================================
// fsm_101_pkg
// State encodings and sync pattern shared by the "101" transmitter and detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fsm_101_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SYNC = 2'b01,
        S_DATA = 2'b10,
        S_GAP  = 2'b11
    } state_t;

    localparam logic [2:0] SYNC_PAT = 3'b101;
    localparam int         SYNC_LEN = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_101_tx_piso_shift.sv
// ============================================================================
// piso_shift
// Parallel-in serial-out register: load a word, shift left, expose the MSB.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             msb
);

    logic [WIDTH-1:0] sr_r;

    always_ff @(posedge clk) begin
        if (clr) begin
            sr_r <= '0;
        end else if (load) begin
            sr_r <= load_data;
        end else if (shift) begin
            sr_r <= sr_r << 1;
        end
    end

    assign msb = sr_r[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_101_tx.sv
// ============================================================================
// seq_101_tx
// Serial frame transmitter: sync 1,0,1 then MSB-first payload then idle zeros.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_101_tx
    import fsm_101_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       cs
);

    localparam int CNT_W = $clog2(max3(SYNC_LEN, WIDTH, GAP_LEN)) + 1;

    state_t           state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             sout_r, sout_nxt;
    logic             done_r, done_nxt;
    logic             xfer;
    logic             shift;
    logic             msb;
    logic [1:0]       sync_idx;

    assign in_ready = (state_r == S_IDLE);
    assign xfer     = in_valid && in_ready;
    // Bit to send next while still in SYNC: pattern walks down as the counter does.
    assign sync_idx = cnt_r[1:0] - 2'd1;

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk       (clk),
        .clr       (clr),
        .load      (xfer),
        .load_data (in_data),
        .shift     (shift),
        .msb       (msb)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            sout_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            sout_r  <= sout_nxt;
            done_r  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        sout_nxt  = 1'b0;
        done_nxt  = 1'b0;
        shift     = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_nxt = '0;
                if (xfer) begin
                    state_nxt = S_SYNC;
                    cnt_nxt   = CNT_W'(SYNC_LEN - 1);
                    sout_nxt  = SYNC_PAT[2];
                end
            end
            S_SYNC: begin
                if (cnt_r == '0) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = CNT_W'(WIDTH - 1);
                    sout_nxt  = msb;
                    shift     = 1'b1;
                end else begin
                    cnt_nxt  = cnt_r - 1'b1;
                    sout_nxt = SYNC_PAT[sync_idx];
                end
            end
            S_DATA: begin
                if (cnt_r == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = CNT_W'(GAP_LEN - 1);
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt_r - 1'b1;
                    sout_nxt = msb;
                    shift    = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_r == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt_r - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign sout = sout_r;
    assign done = done_r;
    assign busy = (state_r != S_IDLE);
    assign cs   = state_r;

endmodule

`default_nettype wire

// File: tb/tb_seq_101_tx.sv
// ============================================================================
// tb_seq_101_tx
// Directed self-checking bench for seq_101_tx, including a 101-detector loopback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_101_tx;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, sout, busy, done;
    logic [1:0] cs;

    logic       in_valid4 = 1'b0;
    logic [3:0] in_data4 = 4'h0;
    logic       in_ready4, sout4, busy4, done4;
    logic [1:0] cs4;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_101_tx #(.WIDTH(8), .GAP_LEN(2)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sout(sout), .busy(busy), .done(done), .cs(cs)
    );

    seq_101_tx #(.WIDTH(4), .GAP_LEN(2)) dut4 (
        .clk(clk), .clr(clr), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .sout(sout4), .busy(busy4), .done(done4), .cs(cs4)
    );

    // Moore 101 detector, overlapping: 0=none, 1=saw 1, 2=saw 10, 3=saw 101 (out=1)
    logic [1:0] det_st;
    logic       det_out;
    always_ff @(posedge clk) begin
        if (clr) det_st <= 2'd0;
        else begin
            case (det_st)
                2'd0: det_st <= sout4 ? 2'd1 : 2'd0;
                2'd1: det_st <= sout4 ? 2'd1 : 2'd2;
                2'd2: det_st <= sout4 ? 2'd3 : 2'd0;
                default: det_st <= sout4 ? 2'd1 : 2'd2;
            endcase
        end
    end
    assign det_out = (det_st == 2'd3);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected sout in cycle i (0-based after transfer) of an 8-bit frame
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        logic [2:0] p;
        p = 3'b101;
        if (i < 3)       return p[2-i];
        else if (i < 11) return d[10-i];
        else             return 1'b0;
    endfunction

    task automatic test_reset();
        clr = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        step(); step();
        n_total++;
        if (cs !== 2'b00 || sout !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: cs=%b sout=%b rdy=%b busy=%b done=%b want 00 0 1 0 0", cs, sout, in_ready, busy, done);
        end
        clr = 1'b0; in_valid = 1'b0;
        step(); step();
        n_total++;
        if (cs !== 2'b00 || sout !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_hold: cs=%b sout=%b rdy=%b want 00 0 1", cs, sout, in_ready);
        end
    endtask

    task automatic test_single_frame();
        int errs;
        errs = 0;
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 13; i++) begin
            n_total++;
            if (sout !== frame_bit(8'hA5, i) || done !== (i == 11) || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL single_frame bit %0d: sout=%b done=%b rdy=%b busy=%b want sout=%b done=%b rdy=0 busy=1",
                         i, sout, done, in_ready, busy, frame_bit(8'hA5, i), (i == 11));
            end
            step();
        end
        n_total++;
        if (in_ready !== 1'b1 || cs !== 2'b00 || sout !== 1'b0) begin
            n_bad++;
            $display("FAIL single_frame_end: rdy=%b cs=%b sout=%b want 1 00 0", in_ready, cs, sout);
        end
    endtask

    task automatic test_back_to_back();
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_data = 8'h00;
        for (int i = 0; i < 13; i++) begin
            n_total++;
            if (sout !== frame_bit(8'hFF, i) || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_ff bit %0d: sout=%b rdy=%b want sout=%b rdy=0", i, sout, in_ready, frame_bit(8'hFF, i));
            end
            step();
        end
        n_total++;
        if (cs !== 2'b00 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gap_idle: cs=%b rdy=%b want 00 1", cs, in_ready);
        end
        step();
        in_valid = 1'b0;
        n_total++;
        if (cs !== 2'b01 || sout !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_xfer: cs=%b sout=%b want 01 1", cs, sout);
        end
        for (int i = 0; i < 13; i++) begin
            n_total++;
            if (sout !== frame_bit(8'h00, i) || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_00 bit %0d: sout=%b rdy=%b want sout=%b rdy=0", i, sout, in_ready, frame_bit(8'h00, i));
            end
            step();
        end
        n_total++;
        if (cs !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_end: cs=%b want 00", cs);
        end
    endtask

    task automatic test_ignore_busy();
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) begin in_valid = 1'b1; in_data = 8'h3C; end
            else if (i == 6) begin in_valid = 1'b0; end
            n_total++;
            if (sout !== frame_bit(8'hA5, i)) begin
                n_bad++;
                $display("FAIL ignore_busy bit %0d: sout=%b want %b", i, sout, frame_bit(8'hA5, i));
            end
            step();
        end
        step();
        n_total++;
        if (cs !== 2'b00 || sout !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_busy_end: cs=%b sout=%b want 00 0", cs, sout);
        end
    endtask

    task automatic test_abort();
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_total++;
        if (cs !== 2'b10 || sout !== frame_bit(8'hA5, 5)) begin
            n_bad++;
            $display("FAIL abort_pre: cs=%b sout=%b want 10 %b", cs, sout, frame_bit(8'hA5, 5));
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_total++;
        if (cs !== 2'b00 || sout !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort: cs=%b sout=%b done=%b busy=%b want 00 0 0 0", cs, sout, done, busy);
        end
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (done !== 1'b0 || sout !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_quiet %0d: done=%b sout=%b want 0 0", i, done, sout);
            end
            step();
        end
        in_data = 8'h81; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            n_total++;
            if (sout !== frame_bit(8'h81, i) || done !== (i == 11)) begin
                n_bad++;
                $display("FAIL after_abort bit %0d: sout=%b done=%b want %b %b", i, sout, done, frame_bit(8'h81, i), (i == 11));
            end
            step();
        end
    endtask

    task automatic test_loopback();
        int hits;
        int first;
        logic [8:0] exp4;
        hits = 0; first = -1;
        exp4 = 9'b101000000;
        in_data4 = 4'h0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 9) begin
                n_total++;
                if (sout4 !== exp4[8-i]) begin
                    n_bad++;
                    $display("FAIL loop_sout bit %0d: sout=%b want %b", i, sout4, exp4[8-i]);
                end
            end
            if (det_out === 1'b1) begin
                hits++;
                if (first < 0) first = i;
            end
            step();
        end
        n_total++;
        if (hits != 1 || first != 3) begin
            n_bad++;
            $display("FAIL loopback_detect: hits=%0d at=%0d want hits=1 at=3", hits, first);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        test_loopback();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
